// File: rtl/ad_capture_ctrl.sv
// AD capture controller: per-PRI FIFO flush, waveform-dependent read delay,
// windowed FIFO read-out and a blanking (bisuo) gate timed from the PRI edge.
// Optional macro AD_CAPTURE_UNDERRUN_CNT_EN builds the underrun counter;
// without it underrun_cnt is tied to 0.
module ad_capture_ctrl #(
  parameter int unsigned FLUSH_CYC  = 4,
  parameter int unsigned BISUO_UNIT = 100
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        PRI,
  input  logic [7:0]  wave_code,
  input  logic [13:0] win_len,
  input  logic        bisuo_sclr,
  input  logic [7:0]  bisuo_st,
  input  logic [7:0]  bisuo_width,
  input  logic        fifo_empty,
  output logic        fifo_rst,
  output logic        rd_en,
  output logic        data_valid,
  output logic        bisuo_gate,
  output logic        busy,
  output logic [7:0]  underrun_cnt
);

  typedef enum logic [2:0] {StIdle, StFlush, StDelay, StRead, StDone} state_e;

  localparam logic [13:0] CntMax = 14'h3fff;

  state_e      state_q, state_d;
  logic        pri_q;
  logic        pri_edge;
  logic        started_q, started_d;
  logic [13:0] cnt_q, cnt_d;
  logic [7:0]  wave_q;
  logic [13:0] win_q;
  logic [13:0] rd_cnt_q;
  logic [13:0] read_dly;
  logic [14:0] cnt_nxt;
  logic        go_read;
  logic        flush_last;
  logic        win_hit;
  logic [15:0] gate_lo, gate_hi;
  logic        gate_d, gate_q;
  logic        data_valid_q;

  assign pri_edge  = PRI & ~pri_q;
  assign started_d = started_q | pri_edge;

  // Free-running time base since the last PRI edge, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (pri_edge) begin
      cnt_d = 14'd0;
    end else if (started_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  // Edge detector, time base and per-PRI latched configuration
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      pri_q     <= 1'b1;  // a PRI already high at reset release is not an edge
      started_q <= 1'b0;
      cnt_q     <= 14'd0;
      wave_q    <= 8'd0;
      win_q     <= 14'd0;
    end else begin
      pri_q     <= PRI;
      started_q <= started_d;
      cnt_q     <= cnt_d;
      if (pri_edge) begin
        wave_q <= wave_code;
        win_q  <= win_len;
      end
    end
  end

  // Read delay table indexed by the latched waveform code
  always_comb begin
    case (wave_q)
      8'h01:        read_dly = 14'd400;
      8'h02:        read_dly = 14'd1200;
      8'h03:        read_dly = 14'd1900;
      8'h04:        read_dly = 14'd190;
      8'h05, 8'h06: read_dly = 14'd3900;
      8'h07:        read_dly = 14'd9900;
      default:      read_dly = 14'd0;
    endcase
  end

  // Transition conditions look at the cnt value of the next cycle so that
  // READ is entered exactly on the first cycle with cnt > D
  assign cnt_nxt    = {1'b0, cnt_q} + 15'd1;
  assign go_read    = (cnt_nxt > {1'b0, read_dly}) && (32'(cnt_nxt) >= FLUSH_CYC);
  assign flush_last = (32'(cnt_q) + 32'd1) >= FLUSH_CYC;
  assign win_hit    = (win_q != 14'd0) && ((rd_cnt_q + 14'd1) == win_q);

  // FSM state register
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a PRI edge restarts the sequence from any state
  always_comb begin
    state_d = state_q;
    if (pri_edge) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StFlush: if (flush_last) state_d = go_read ? StRead : StDelay;
        StDelay: if (go_read) state_d = StRead;
        StRead:  if (rd_en && win_hit) state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs, decoded from the registered state
  always_comb begin
    fifo_rst = (state_q == StFlush);
    rd_en    = (state_q == StRead) && !fifo_empty;
    busy     = (state_q == StFlush) || (state_q == StDelay) || (state_q == StRead);
  end

  // Number of FIFO words read in the current PRI
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 14'd0;
    end else if (pri_edge) begin
      rd_cnt_q <= 14'd0;
    end else if (rd_en) begin
      rd_cnt_q <= rd_cnt_q + 14'd1;
    end
  end

  // FIFO dout is valid the cycle after the read strobe
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_en;
    end
  end
  assign data_valid = data_valid_q;

  // Blanking bounds in 16 bits; the upper bound may exceed the saturated cnt
  assign gate_lo = 16'(32'(bisuo_st) * BISUO_UNIT);
  assign gate_hi = 16'((32'(bisuo_st) + 32'(bisuo_width)) * BISUO_UNIT);

  // Gate is evaluated on the upcoming cnt so the registered output lines up with cnt
  always_comb begin
    gate_d = started_d && !bisuo_sclr && (bisuo_width != 8'd0) &&
             ({2'b00, cnt_d} >= gate_lo) && ({2'b00, cnt_d} < gate_hi);
  end

  // Registered blanking gate
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate_d;
    end
  end
  assign bisuo_gate = gate_q;

`ifdef AD_CAPTURE_UNDERRUN_CNT_EN
  logic [7:0] underrun_q;

  // Saturating count of READ cycles stalled on an empty FIFO
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 8'd0;
    end else if (pri_edge) begin
      underrun_q <= 8'd0;
    end else if ((state_q == StRead) && fifo_empty && (underrun_q != 8'hff)) begin
      underrun_q <= underrun_q + 8'd1;
    end
  end
  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Bench for ad_capture_ctrl: per-cycle reference model plus scenario table,
// hand-written PRI-retrigger and reset sequences, and a random phase.
module tb_ad_capture_ctrl;

  localparam int FLUSH = 4;
  localparam int UNIT  = 100;
`ifdef AD_CAPTURE_UNDERRUN_CNT_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic        clk_100M = 1'b0;
  logic        rst_n;
  logic        PRI;
  logic [7:0]  wave_code;
  logic [13:0] win_len;
  logic        bisuo_sclr;
  logic [7:0]  bisuo_st;
  logic [7:0]  bisuo_width;
  logic        fifo_empty;
  logic        fifo_rst;
  logic        rd_en;
  logic        data_valid;
  logic        bisuo_gate;
  logic        busy;
  logic [7:0]  underrun_cnt;

  always #5 clk_100M = ~clk_100M;

  ad_capture_ctrl #(
    .FLUSH_CYC (FLUSH),
    .BISUO_UNIT(UNIT)
  ) dut (
    .clk_100M    (clk_100M),
    .rst_n       (rst_n),
    .PRI         (PRI),
    .wave_code   (wave_code),
    .win_len     (win_len),
    .bisuo_sclr  (bisuo_sclr),
    .bisuo_st    (bisuo_st),
    .bisuo_width (bisuo_width),
    .fifo_empty  (fifo_empty),
    .fifo_rst    (fifo_rst),
    .rd_en       (rd_en),
    .data_valid  (data_valid),
    .bisuo_gate  (bisuo_gate),
    .busy        (busy),
    .underrun_cnt(underrun_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time since last PRI edge, reads done, stalls seen
  bit m_active, m_prev_pri, m_prev_rd, m_gate;
  int m_t, m_reads, m_under, m_dly, m_win;

  bit o_rd, o_rst, o_busy, o_gate;
  int o_under;

  function automatic int dly_of(input int w);
    case (w)
      1:       return 400;
      2:       return 1200;
      3:       return 1900;
      4:       return 190;
      5, 6:    return 3900;
      7:       return 9900;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_t = 0; m_reads = 0; m_under = 0; m_dly = 0; m_win = 0;
    m_prev_pri = 1; m_prev_rd = 0; m_gate = 0;
  endtask

  // One clock cycle: drive at negedge, check, advance model at posedge
  task automatic step(input bit pri, input bit empty);
    int start, lo, hi;
    bit in_read, e_rd, edge_seen;
    PRI = pri;
    fifo_empty = empty;
    #1;
    start   = (m_dly + 1 > FLUSH) ? m_dly + 1 : FLUSH;
    in_read = m_active && (m_t >= start) && (m_win == 0 || m_reads < m_win);
    e_rd    = in_read && !empty;
    check("rd_en", int'(rd_en), int'(e_rd));
    check("fifo_rst", int'(fifo_rst), int'(m_active && m_t < FLUSH));
    check("busy", int'(busy), int'(m_active && (m_t < start || in_read)));
    check("data_valid", int'(data_valid), int'(m_prev_rd));
    check("bisuo_gate", int'(bisuo_gate), int'(m_gate));
    check("underrun_cnt", int'(underrun_cnt), UR_EN ? m_under : 0);
    o_rd = rd_en; o_rst = fifo_rst; o_busy = busy; o_gate = bisuo_gate;
    o_under = int'(underrun_cnt);
    @(posedge clk_100M);
    edge_seen  = pri && !m_prev_pri;
    m_prev_pri = pri;
    m_prev_rd  = e_rd;
    if (edge_seen) begin
      m_active = 1; m_t = 0; m_reads = 0; m_under = 0;
      m_dly = dly_of(int'(wave_code)); m_win = int'(win_len);
    end else if (m_active) begin
      if (e_rd) m_reads++;
      if (in_read && empty && m_under < 255) m_under++;
      if (m_t < 16383) m_t++;
    end
    lo = int'(bisuo_st) * UNIT;
    hi = (int'(bisuo_st) + int'(bisuo_width)) * UNIT;
    m_gate = m_active && !bisuo_sclr && bisuo_width != 0 && m_t >= lo && m_t < hi;
    @(negedge clk_100M);
  endtask

  typedef struct {
    logic [7:0] wave;
    int win, gap_st, gap_len;
    bit sclr;
    int st, w, hold, run;
    int e_first, e_last, e_pulses, e_under, e_fall, e_gf, e_gl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int first, last, pulses, fall, gf, gl, rstc;
    tbl[0] = '{8'h01, 100, -1, 0, 1'b0, 2, 3, 1, 520, 401, 500, 100, 0, 501, 200, 499};
    tbl[1] = '{8'h01, 100, -1, 0, 1'b1, 2, 3, 1, 520, 401, 500, 100, 0, 501, -1, -1};
    tbl[2] = '{8'h04, 10, 195, 5, 1'b0, 1, 1, 1, 225, 191, 205, 10, 5, 206, 100, 199};
    tbl[3] = '{8'h02, 5, -1, 0, 1'b0, 0, 0, 3, 1220, 1201, 1205, 5, 0, 1206, -1, -1};
    tbl[4] = '{8'h00, 3, -1, 0, 1'b0, 0, 0, 1, 30, 4, 6, 3, 0, 7, -1, -1};
    tbl[5] = '{8'h55, 1, -1, 0, 1'b0, 0, 0, 1, 30, 4, 4, 1, 0, 5, -1, -1};
    tbl[6] = '{8'h03, 2, 1901, 3, 1'b0, 0, 0, 1, 1930, 1904, 1905, 2, 3, 1906, -1, -1};
    tbl[7] = '{8'h05, 1, -1, 0, 1'b0, 0, 0, 1, 3920, 3901, 3901, 1, 0, 3902, -1, -1};
    tbl[8] = '{8'h06, 1, -1, 0, 1'b0, 0, 1, 1, 3920, 3901, 3901, 1, 0, 3902, 0, 99};

    rst_n = 0; PRI = 0; wave_code = 0; win_len = 0; bisuo_sclr = 0;
    bisuo_st = 0; bisuo_width = 0; fifo_empty = 0;
    model_reset();
    repeat (3) @(negedge clk_100M);
    rst_n = 1;
    repeat (5) step(1'b0, 1'b0);

    // Scenario table
    for (int i = 0; i < 9; i++) begin
      wave_code = tbl[i].wave; win_len = 14'(tbl[i].win);
      bisuo_sclr = tbl[i].sclr; bisuo_st = 8'(tbl[i].st); bisuo_width = 8'(tbl[i].w);
      step(1'b1, 1'b0);
      first = -1; last = -1; pulses = 0; fall = -1; gf = -1; gl = -1; rstc = 0;
      for (int c = 0; c < tbl[i].run; c++) begin
        step(c < tbl[i].hold - 1, c >= tbl[i].gap_st && c < tbl[i].gap_st + tbl[i].gap_len);
        if (o_rd) begin
          if (first < 0) first = c;
          last = c;
          pulses++;
        end
        if (!o_busy && fall < 0) fall = c;
        if (o_gate) begin
          if (gf < 0) gf = c;
          gl = c;
        end
        if (o_rst) rstc++;
      end
      check("tbl_first_rd", first, tbl[i].e_first);
      check("tbl_last_rd", last, tbl[i].e_last);
      check("tbl_pulses", pulses, tbl[i].e_pulses);
      check("tbl_busy_fall", fall, tbl[i].e_fall);
      check("tbl_gate_first", gf, tbl[i].e_gf);
      check("tbl_gate_last", gl, tbl[i].e_gl);
      check("tbl_flush_len", rstc, FLUSH);
      check("tbl_underrun", o_under, UR_EN ? tbl[i].e_under : 0);
    end

    // Unbounded window retriggered by a second PRI at cnt 9950
    wave_code = 8'h07; win_len = 14'd0; bisuo_st = 0; bisuo_width = 0; bisuo_sclr = 0;
    step(1'b1, 1'b0);
    first = -1;
    for (int c = 0; c < 9950; c++) begin
      step(1'b0, c >= 9920 && c < 9923);
      if (o_rd && first < 0) first = c;
    end
    check("w7_first_rd", first, 9901);
    step(1'b1, 1'b0);
    check("w7_rd_at_edge", int'(o_rd), 1);
    check("w7_under_before", o_under, UR_EN ? 3 : 0);
    first = -1; rstc = 0;
    for (int c = 0; c < 9910; c++) begin
      step(1'b0, 1'b0);
      if (c == 0) begin
        check("w7_rd_after_edge", int'(o_rd), 0);
        check("w7_under_clr", o_under, 0);
      end
      if (o_rd && first < 0) first = c;
      if (o_rst) rstc++;
    end
    check("w7_flush_len", rstc, FLUSH);
    check("w7_new_first_rd", first, 9901);

    // Asynchronous reset in the middle of READ
    wave_code = 8'h04; win_len = 14'd0; bisuo_st = 0; bisuo_width = 2;
    step(1'b1, 1'b0);
    repeat (200) step(1'b0, 1'b0);
    check("pre_rst_rd", int'(o_rd), 1);
    rst_n = 0;
    #1;
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_fifo_rst", int'(fifo_rst), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_gate", int'(bisuo_gate), 0);
    check("rst_underrun", int'(underrun_cnt), 0);
    model_reset();
    repeat (2) @(negedge clk_100M);
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      step(1'b0, 1'b0);
      if (o_rd || o_busy) pulses++;
    end
    check("post_rst_idle", pulses, 0);

    // Random phase against the reference model
    for (int c = 0; c < 6000; c++) begin
      logic [7:0] picks [5];
      picks[0] = 8'h00; picks[1] = 8'h04; picks[2] = 8'h04;
      picks[3] = 8'h01; picks[4] = 8'h55;
      wave_code   = picks[$urandom_range(0, 4)];
      win_len     = 14'($urandom_range(0, 40));
      bisuo_st    = 8'($urandom_range(0, 5));
      bisuo_width = 8'($urandom_range(0, 4));
      bisuo_sclr  = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 299) < 2, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
